// File: rtl/fetch_mem_responder_pkg.sv
// Shared types and constants for the fetch-stage instruction-memory responder.
// Holds the FSM state encoding, default widths and the NOP used for killed slots.
package fetch_mem_responder_pkg;

  localparam int              DEFAULT_XLEN      = 32;
  localparam logic [31:0]     DEFAULT_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  // A fetch PC must be word aligned; any set low bit means the slot is a NOP.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage : fetch_mem_responder_pkg

// File: rtl/fetch_mem_responder_if.sv
// Fetch/decode/instruction-memory signal bundle around the fetch responder.
// The slave modport is the responder itself; master is whoever drives PC, memory and decode.
interface fetch_mem_responder_if
  import fetch_mem_responder_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
);

  // Fetch PC register and pipeline control
  logic [XLEN-1:0] pc_f;
  logic            flush;
  logic            decode_stall;
  logic            stall_f;

  // Instruction memory
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  // Decode
  logic [XLEN-1:0] instr_f;
  logic            instr_valid;
  logic            misalign_f;

  modport slave (
    input  pc_f, flush, decode_stall, mem_rdata, mem_ready,
    output mem_req, mem_addr, instr_f, instr_valid, misalign_f, stall_f
  );

  modport master (
    output pc_f, flush, decode_stall, mem_rdata, mem_ready,
    input  mem_req, mem_addr, instr_f, instr_valid, misalign_f, stall_f
  );

endinterface : fetch_mem_responder_if

// File: rtl/fetch_mem_responder.sv
// Runs one variable-latency instruction-memory read per fetch PC and hands the word to decode,
// holding the PC (stall_f) until delivery; handles branch flush and misaligned PCs.
module fetch_mem_responder
  import fetch_mem_responder_pkg::*;
#(
  parameter int              XLEN      = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(DEFAULT_NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_mem_responder_if.slave  bus
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            misalign_q, misalign_d;

  logic            mem_req;
  logic            instr_valid;
  logic            stall_f;

  // NOTE: every state element uses non-blocking assignments so all registers update
  // together from the values they held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      instr_q    <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    misalign_d  = misalign_q;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    stall_f     = 1'b1;

    unique case (state_q)
      IDLE: begin
        addr_d = bus.pc_f;
        if (!bus.flush) begin
          if (pc_misaligned(bus.pc_f[1:0])) begin
            instr_d    = NOP_INSTR;
            misalign_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d    = BUSY;
          end
        end
      end

      BUSY: begin
        mem_req = 1'b1;
        if (bus.flush) begin
          // An accepted request cannot be withdrawn, so an unfinished one is drained.
          state_d = bus.mem_ready ? IDLE : DRAIN;
        end else if (bus.mem_ready) begin
          instr_d    = bus.mem_rdata;
          misalign_d = 1'b0;
          state_d    = DONE;
        end
      end

      DRAIN: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          state_d = IDLE;
        end
      end

      DONE: begin
        instr_valid = !bus.flush;
        stall_f     = bus.decode_stall;
        if (bus.flush || !bus.decode_stall) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A redirect always lets the PC register load the new target.
    if (bus.flush) begin
      stall_f = 1'b0;
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = mem_req ? addr_q : '0;
  assign bus.instr_valid = instr_valid;
  assign bus.instr_f     = instr_valid ? instr_q : NOP_INSTR;
  assign bus.misalign_f  = instr_valid & misalign_q;
  assign bus.stall_f     = stall_f;

`ifndef SYNTHESIS
  // The memory sees a stable request until it completes it.
  a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_req && !bus.mem_ready |=> bus.mem_req && $stable(bus.mem_addr));

  // A stalled delivery is held unchanged unless a flush kills it.
  a_hold_instr : assert property (@(posedge clk) disable iff (!rst_n)
    bus.instr_valid && bus.decode_stall && !bus.flush
      |=> bus.flush || (bus.instr_valid && $stable(bus.instr_f)));

  // Memory is only addressed with word-aligned fetch PCs.
  a_aligned_req : assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_req |-> bus.mem_addr[1:0] == 2'b00);
`endif

endmodule : fetch_mem_responder

// File: tb/tb_fetch_mem_responder.sv
// Directed bench for fetch_mem_responder: inputs change just after the falling edge and
// outputs are sampled 1 ns later, one scenario per task.
module tb_fetch_mem_responder;
  import fetch_mem_responder_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fetch_mem_responder_if bus ();

  fetch_mem_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, stall_f, instr_valid, misalign_f}
  logic [3:0] ctl;
  assign ctl = {bus.mem_req, bus.stall_f, bus.instr_valid, bus.misalign_f};

  task automatic test_reset();
    #2;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL reset_ctl got %b want %b", ctl, 4'b0100);
    end
    vectors++;
    if (bus.mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_addr got %h want %h", bus.mem_addr, 32'h0);
    end
    vectors++;
    if (bus.instr_f !== NOP) begin
      miscompares++; $display("FAIL reset_instr got %h want %h", bus.instr_f, NOP);
    end
  endtask

  task automatic test_zero_wait();
    bus.pc_f = 32'h0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0050_0093;
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL zw_idle ctl got %b want %b", ctl, 4'b0100);
    end
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL zw_busy ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h0);
    end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0010 || bus.instr_f !== 32'h0050_0093) begin
      miscompares++; $display("FAIL zw_done ctl/instr got %b/%h want %b/%h", ctl, bus.instr_f, 4'b0010, 32'h0050_0093);
    end
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL zw_back_idle ctl got %b want %b", ctl, 4'b0100);
    end
  endtask

  task automatic test_wait_states();
    bus.pc_f = 32'h10; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (ctl !== 4'b1100 || bus.mem_addr !== 32'h10) begin
        miscompares++; $display("FAIL ws_wait%0d ctl/addr got %b/%h want %b/%h", i, ctl, bus.mem_addr, 4'b1100, 32'h10);
      end
    end
    @(negedge clk); bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00A0_0113; #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h10) begin
      miscompares++; $display("FAIL ws_ready ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h10);
    end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0010 || bus.instr_f !== 32'h00A0_0113) begin
      miscompares++; $display("FAIL ws_done ctl/instr got %b/%h want %b/%h", ctl, bus.instr_f, 4'b0010, 32'h00A0_0113);
    end
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL ws_idle ctl got %b want %b", ctl, 4'b0100);
    end
  endtask

  task automatic test_flush_drain();
    bus.pc_f = 32'h20;
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h20) begin
      miscompares++; $display("FAIL fd_busy ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h20);
    end
    @(negedge clk); bus.flush = 1'b1; #1;
    vectors++;
    if (ctl !== 4'b1000 || bus.mem_addr !== 32'h20) begin
      miscompares++; $display("FAIL fd_flush ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1000, 32'h20);
    end
    @(negedge clk); bus.flush = 1'b0; bus.pc_f = 32'h40; #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h20) begin
      miscompares++; $display("FAIL fd_drain1 ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h20);
    end
    @(negedge clk); bus.flush = 1'b1; #1;
    vectors++;
    if (ctl !== 4'b1000 || bus.mem_addr !== 32'h20) begin
      miscompares++; $display("FAIL fd_drain2 ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1000, 32'h20);
    end
    @(negedge clk); bus.flush = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0; #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h20) begin
      miscompares++; $display("FAIL fd_drain3 ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h20);
    end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL fd_idle ctl got %b want %b", ctl, 4'b0100);
    end
    @(negedge clk); bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0010_8093; #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h40) begin
      miscompares++; $display("FAIL fd_newpc ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h40);
    end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0010 || bus.instr_f !== 32'h0010_8093) begin
      miscompares++; $display("FAIL fd_done ctl/instr got %b/%h want %b/%h", ctl, bus.instr_f, 4'b0010, 32'h0010_8093);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_flush_with_ready();
    bus.pc_f = 32'h30;
    @(negedge clk); bus.flush = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_1111; #1;
    vectors++;
    if (ctl !== 4'b1000 || bus.mem_addr !== 32'h30) begin
      miscompares++; $display("FAIL fr_busy ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1000, 32'h30);
    end
    @(negedge clk); bus.flush = 1'b0; bus.mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL fr_idle ctl got %b want %b", ctl, 4'b0100);
    end
  endtask

  task automatic test_decode_stall();
    bus.pc_f = 32'h50; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0031_0193; bus.decode_stall = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h50) begin
      miscompares++; $display("FAIL ds_busy ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h50);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.mem_ready = 1'b0; #1;
      vectors++;
      if (ctl !== 4'b0110 || bus.instr_f !== 32'h0031_0193) begin
        miscompares++; $display("FAIL ds_hold%0d ctl/instr got %b/%h want %b/%h", i, ctl, bus.instr_f, 4'b0110, 32'h0031_0193);
      end
    end
    @(negedge clk); bus.decode_stall = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0010 || bus.instr_f !== 32'h0031_0193) begin
      miscompares++; $display("FAIL ds_release ctl/instr got %b/%h want %b/%h", ctl, bus.instr_f, 4'b0010, 32'h0031_0193);
    end
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL ds_idle ctl got %b want %b", ctl, 4'b0100);
    end
  endtask

  task automatic test_flush_in_done();
    bus.pc_f = 32'h60; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0073;
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h60) begin
      miscompares++; $display("FAIL fdn_busy ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h60);
    end
    @(negedge clk); bus.mem_ready = 1'b0; bus.decode_stall = 1'b1; bus.flush = 1'b1; #1;
    vectors++;
    if (ctl !== 4'b0000 || bus.instr_f !== NOP) begin
      miscompares++; $display("FAIL fdn_done ctl/instr got %b/%h want %b/%h", ctl, bus.instr_f, 4'b0000, NOP);
    end
    @(negedge clk); bus.flush = 1'b0; bus.decode_stall = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL fdn_idle ctl got %b want %b", ctl, 4'b0100);
    end
  endtask

  task automatic test_misalign();
    bus.pc_f = 32'h0000_0006; bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b0011 || bus.instr_f !== NOP) begin
      miscompares++; $display("FAIL ma_done ctl/instr got %b/%h want %b/%h", ctl, bus.instr_f, 4'b0011, NOP);
    end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL ma_idle ctl got %b want %b", ctl, 4'b0100);
    end
  endtask

  task automatic test_reset_mid_busy();
    bus.pc_f = 32'h70; bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h70) begin
      miscompares++; $display("FAIL rb_busy ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h70);
    end
    #2; rst_n = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0100 || bus.mem_addr !== 32'h0 || bus.instr_f !== NOP) begin
      miscompares++; $display("FAIL rb_async ctl/addr/instr got %b/%h/%h want %b/%h/%h",
                              ctl, bus.mem_addr, bus.instr_f, 4'b0100, 32'h0, NOP);
    end
    @(negedge clk); rst_n = 1'b1; bus.pc_f = 32'h80; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0040_0213; #1;
    vectors++;
    if (ctl !== 4'b0100) begin
      miscompares++; $display("FAIL rb_idle ctl got %b want %b", ctl, 4'b0100);
    end
    @(negedge clk); #1;
    vectors++;
    if (ctl !== 4'b1100 || bus.mem_addr !== 32'h80) begin
      miscompares++; $display("FAIL rb_rebusy ctl/addr got %b/%h want %b/%h", ctl, bus.mem_addr, 4'b1100, 32'h80);
    end
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    vectors++;
    if (ctl !== 4'b0010 || bus.instr_f !== 32'h0040_0213) begin
      miscompares++; $display("FAIL rb_done ctl/instr got %b/%h want %b/%h", ctl, bus.instr_f, 4'b0010, 32'h0040_0213);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst_n            = 1'b0;
    bus.pc_f         = '0;
    bus.flush        = 1'b0;
    bus.decode_stall = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = '0;

    test_reset();
    test_zero_wait();
    test_wait_states();
    test_flush_drain();
    test_flush_with_ready();
    test_decode_stall();
    test_flush_in_done();
    test_misalign();
    test_reset_mid_busy();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_mem_responder
